// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes, frame geometry.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int FRAME_BITS = 11;
    localparam int CNT_W      = 20;

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizer for PS2_CLK/PS2_DAT plus a registered falling-edge strobe on the clock line.
module ps2_line_sync (
    input  logic clk,
    input  logic resetn,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fall
);

    logic [1:0] clk_ff_q;
    logic [1:0] dat_ff_q;
    logic       clk_prev_q;
    logic       fall_q;

    // Reset to the idle-high line level so leaving reset never fakes a falling edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_ff_q   <= 2'b11;
            dat_ff_q   <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_ff_q   <= {clk_ff_q[0], clk_in};
            dat_ff_q   <= {dat_ff_q[0], dat_in};
            clk_prev_q <= clk_ff_q[1];
            fall_q     <= clk_prev_q & ~clk_ff_q[1];
        end
    end

    assign clk_s    = clk_ff_q[1];
    assign dat_s    = dat_ff_q[1];
    assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned REQ_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       data_q, data_d;
    logic             ack_q, ack_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_s, dat_s, clk_fall;
    logic in_frame;

    ps2_line_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .clk_in   (ps2_clk_in),
        .dat_in   (ps2_dat_in),
        .clk_s    (clk_s),
        .dat_s    (dat_s),
        .clk_fall (clk_fall)
    );

    assign in_frame = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        ack_d    = ack_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                if (send) begin
                    data_d   = {~^tx_byte, tx_byte};
                    bit_d    = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(REQ_CYCLES - 1)) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_fall) begin
                    bit_d = bit_q + 1'b1;
                    // Falls 1..9 carry data then parity; fall 10 releases data as the stop bit.
                    if (bit_q < 4'd9) begin
                        dat_oe_d = ~data_q[bit_q];
                    end else begin
                        dat_oe_d = 1'b0;
                    end
                    if (bit_q == 4'(FRAME_BITS - 2)) state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_fall) begin
                    ack_d   = dat_s;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_s && dat_s) begin
                    done_d  = ~ack_q;
                    err_d   = ack_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides any completion in the same cycle, so done/error stay exclusive.
        if (in_frame && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on open-drain lines.
module tb_ps2_host_tx;

    localparam int INH  = 6000;
    localparam int REQ  = 50;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       send = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

    int errors = 0;
    int checks = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .send       (send),
        .tx_byte    (tx_byte),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic do_send(input logic [7:0] b);
        @(negedge clk);
        send = 1'b1;
        tx_byte = b;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Device: waits for clock release, clocks nfalls falls, captures line at each rise.
    // fr[0] = start bit (before fall 1), fr[k] = line at rise k.
    task automatic device_frame(input bit ack, input int nfalls, output logic [10:0] fr);
        int w;
        fr = '0;
        w = 0;
        while (ps2_clk_oe !== 1'b0 && w < 10000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 10000) return;
        repeat (HALF) @(negedge clk);
        fr[0] = ps2_dat_in;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == nfalls && nfalls < 11) begin
                repeat (HALF / 2) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) fr[k] = ps2_dat_in;
            if (k == 11) begin
                dev_dat = 1'b1;
                return;
            end
            repeat (HALF / 2) @(negedge clk);
            if (k == 10 && ack) dev_dat = 1'b0;
            repeat (HALF - HALF / 2) @(negedge clk);
        end
    endtask

    task automatic wait_result(output bit dn, output bit er, output bit idle_ok);
        dn = 1'b0;
        er = 1'b0;
        idle_ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin
                dn = done;
                er = error;
                idle_ok = (ps2_clk_oe === 1'b0) && (ps2_dat_oe === 1'b0) && (busy === 1'b0);
                return;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold outs=%b expected 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release outs=%b expected 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
    endtask

    task automatic test_set_leds(input string tag);
        logic [10:0] fr;
        bit dn, er, idl;
        do_send(8'hED);
        device_frame(1'b1, 11, fr);
        wait_result(dn, er, idl);
        checks++;
        if (fr !== 11'h7DA) begin
            errors++;
            $display("FAIL %s_frame got=%h expected=7da", tag, fr);
        end
        checks++;
        if (dn !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL %s_done done=%b error=%b expected done=1 error=0", tag, dn, er);
        end
        checks++;
        if (idl !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle got=%b expected=1 (busy and oe low at done)", tag, idl);
        end
    endtask

    task automatic test_timing_parity0;
        logic [10:0] fr;
        bit dn, er, idl;
        int hi, rise;
        hi = 0;
        rise = 0;
        do_send(8'h01);
        while (ps2_clk_oe === 1'b1 && hi < 10000) begin
            hi++;
            if (ps2_dat_oe === 1'b1 && rise == 0) rise = hi;
            @(negedge clk);
        end
        checks++;
        if (hi != 6050) begin
            errors++;
            $display("FAIL clk_oe_len got=%0d expected=6050", hi);
        end
        checks++;
        if (rise != 6001) begin
            errors++;
            $display("FAIL dat_oe_rise got=%0d expected=6001", rise);
        end
        device_frame(1'b1, 11, fr);
        wait_result(dn, er, idl);
        checks++;
        if (fr !== 11'h402) begin
            errors++;
            $display("FAIL b01_frame got=%h expected=402", fr);
        end
        checks++;
        if (dn !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL b01_done done=%b error=%b expected done=1 error=0", dn, er);
        end
    endtask

    task automatic test_no_ack;
        logic [10:0] fr;
        bit dn, er, idl;
        do_send(8'hFF);
        device_frame(1'b0, 11, fr);
        wait_result(dn, er, idl);
        checks++;
        if (fr !== 11'h7FE) begin
            errors++;
            $display("FAIL nack_frame got=%h expected=7fe", fr);
        end
        checks++;
        if (er !== 1'b1 || dn !== 1'b0) begin
            errors++;
            $display("FAIL nack_error done=%b error=%b expected done=0 error=1", dn, er);
        end
        checks++;
        if (idl !== 1'b1) begin
            errors++;
            $display("FAIL nack_idle got=%b expected=1", idl);
        end
    endtask

    task automatic test_timeout;
        int w, t;
        bit saw_done;
        w = 0;
        t = 0;
        saw_done = 1'b0;
        do_send(8'h00);
        while (ps2_clk_oe !== 1'b0 && w < 10000) begin
            @(negedge clk);
            w++;
        end
        while (error !== 1'b1 && t < TO + 100) begin
            @(negedge clk);
            t++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (t != TO) begin
            errors++;
            $display("FAIL timeout_cycles got=%0d expected=%0d", t, TO);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done got=%b expected=0", saw_done);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_release clk_oe,dat_oe,busy=%b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_send_while_busy;
        logic [10:0] fr;
        bit dn, er, idl;
        do_send(8'hF4);
        repeat (100) @(negedge clk);
        send = 1'b1;
        tx_byte = 8'h55;
        @(negedge clk);
        send = 1'b0;
        tx_byte = 8'h00;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_frame got=%b expected=1", busy);
        end
        device_frame(1'b1, 11, fr);
        wait_result(dn, er, idl);
        checks++;
        if (fr !== 11'h5E8) begin
            errors++;
            $display("FAIL ignore_frame got=%h expected=5e8", fr);
        end
        checks++;
        if (dn !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done done=%b error=%b expected done=1 error=0", dn, er);
        end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] fr;
        do_send(8'hF4);
        device_frame(1'b1, 4, fr);
        // After fall 4 the host drives F4 bit 3 = 0, i.e. pulls data low.
        checks++;
        if (ps2_dat_oe !== 1'b1) begin
            errors++;
            $display("FAIL fall4_bit dat_oe=%b expected=1", ps2_dat_oe);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL midframe_reset outs=%b expected 00000", {ps2_clk_oe, ps2_dat_oe, busy, done, error});
        end
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        test_set_leds("post_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_set_leds("ed");
        test_timing_parity0();
        test_no_ack();
        test_timeout();
        test_send_while_busy();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
